// File: rtl/bp_counter_sampler.sv
// Snapshot-and-clear sampler for a bank of event counters.
// Readout streams one counter per valid/ready beat.
module bp_counter_sampler #(
    parameter int num_counters_p = 22,
    parameter int width_p        = 32,
    parameter int drop_width_p   = 16,
    localparam int idx_w_lp = (num_counters_p > 1) ? $clog2(num_counters_p) : 1
) (
    input  logic                                clk_i,
    input  logic                                reset_n_i,
    input  logic                                en_i,
    input  logic [width_p-1:0]                  period_i,
    input  logic                                trigger_i,
    input  logic [num_counters_p*width_p-1:0]   counters_i,
    output logic                                clear_o,
    output logic                                v_o,
    input  logic                                ready_i,
    output logic [width_p-1:0]                  data_o,
    output logic [idx_w_lp-1:0]                 idx_o,
    output logic                                last_o,
    output logic                                busy_o,
    input  logic                                clear_drop_i,
    output logic [drop_width_p-1:0]             dropped_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SNAP = 2'd1,
        SEND = 2'd2
    } state_e;

    localparam logic [idx_w_lp-1:0] last_idx_lp = idx_w_lp'(num_counters_p - 1);

    state_e                      state_r, state_n;
    logic [width_p-1:0]          timer_r;
    logic [idx_w_lp-1:0]         idx_r;
    logic [width_p-1:0]          snap_r [num_counters_p];
    logic [drop_width_p-1:0]     drop_r;
    logic                        timer_en, tick, req, drop_ev, beat, at_last;

    assign timer_en = en_i && (period_i != '0);
    // >= rather than == so a period shrunk below the timer still wraps
    assign tick     = timer_en && (timer_r >= period_i - width_p'(1));
    assign req      = trigger_i || tick;
    assign drop_ev  = req && (state_r != IDLE);
    assign at_last  = (idx_r == last_idx_lp);
    assign beat     = (state_r == SEND) && ready_i;

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) state_r <= IDLE;
        else            state_r <= state_n;
    end

    always_comb begin
        state_n = state_r;
        unique case (state_r)
            IDLE:    if (req) state_n = SNAP;
            SNAP:    state_n = SEND;
            SEND:    if (ready_i && at_last) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_comb begin
        clear_o = (state_r == SNAP);
        v_o     = (state_r == SEND);
        busy_o  = (state_r != IDLE);
        last_o  = (state_r == SEND) && at_last;
        idx_o   = idx_r;
        data_o  = snap_r[idx_r];
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            timer_r <= '0;
        end else if (!timer_en || tick) begin
            timer_r <= '0;
        end else begin
            timer_r <= timer_r + width_p'(1);
        end
    end

    // Snapshot load coincides with the clear edge so no event is lost
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            idx_r <= '0;
            for (int k = 0; k < num_counters_p; k++) snap_r[k] <= '0;
        end else if (state_r == SNAP) begin
            idx_r <= '0;
            for (int k = 0; k < num_counters_p; k++)
                snap_r[k] <= counters_i[k*width_p +: width_p];
        end else if (beat) begin
            idx_r <= at_last ? '0 : idx_r + idx_w_lp'(1);
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            drop_r <= '0;
        end else if (clear_drop_i) begin
            drop_r <= drop_ev ? drop_width_p'(1) : '0;
        end else if (drop_ev && (drop_r != '1)) begin
            drop_r <= drop_r + drop_width_p'(1);
        end
    end

    assign dropped_o = drop_r;

endmodule

// File: tb/tb_bp_counter_sampler.sv
// Directed bench for bp_counter_sampler.
// Small configuration: 4 counters of 8 bits, 4-bit drop counter.
module tb_bp_counter_sampler;

    localparam int N  = 4;
    localparam int W  = 8;
    localparam int DW = 4;

    logic           clk = 1'b0;
    logic           reset_n = 1'b0;
    logic           en = 1'b0;
    logic [W-1:0]   period = '0;
    logic           trigger = 1'b0;
    logic [N*W-1:0] counters = '0;
    logic           clear;
    logic           v;
    logic           ready = 1'b0;
    logic [W-1:0]   data;
    logic [1:0]     idx;
    logic           last;
    logic           busy;
    logic           clear_drop = 1'b0;
    logic [DW-1:0]  dropped;

    int checks = 0;
    int errors = 0;

    bp_counter_sampler #(
        .num_counters_p(N),
        .width_p(W),
        .drop_width_p(DW)
    ) dut (
        .clk_i(clk),
        .reset_n_i(reset_n),
        .en_i(en),
        .period_i(period),
        .trigger_i(trigger),
        .counters_i(counters),
        .clear_o(clear),
        .v_o(v),
        .ready_i(ready),
        .data_o(data),
        .idx_o(idx),
        .last_o(last),
        .busy_o(busy),
        .clear_drop_i(clear_drop),
        .dropped_o(dropped)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int clr_cnt;
        int beat_cnt;
        logic [7:0] exp_d [4];
        exp_d[0] = 8'd10; exp_d[1] = 8'd20;
        exp_d[2] = 8'd30; exp_d[3] = 8'd40;

        // reset state
        #12;
        chk("rst_v", v, 0);
        chk("rst_busy", busy, 0);
        chk("rst_clear", clear, 0);
        chk("rst_drop", dropped, 0);
        chk("rst_last", last, 0);
        step();
        reset_n = 1'b1;
        step();

        // single trigger, full-speed readout
        counters = {8'd40, 8'd30, 8'd20, 8'd10};
        ready = 1'b1;
        trigger = 1'b1;
        step();
        trigger = 1'b0;
        chk("t1_clear", clear, 1);
        chk("t1_v_snap", v, 0);
        for (int i = 0; i < N; i++) begin
            step();
            chk("t1_v", v, 1);
            chk("t1_clr_off", clear, 0);
            chk("t1_idx", idx, i);
            chk("t1_data", data, exp_d[i]);
            chk("t1_last", last, (i == N - 1));
        end
        step();
        chk("t1_busy_end", busy, 0);
        chk("t1_v_end", v, 0);

        // backpressure at idx 1, counters change during SEND
        trigger = 1'b1;
        step();
        trigger = 1'b0;
        step();
        chk("t2_idx0", idx, 0);
        step();
        chk("t2_idx1", idx, 1);
        ready = 1'b0;
        counters = {8'd99, 8'd88, 8'd77, 8'd66};
        for (int i = 0; i < 5; i++) begin
            step();
            chk("t2_hold_v", v, 1);
            chk("t2_hold_idx", idx, 1);
            chk("t2_hold_data", data, 20);
            chk("t2_hold_last", last, 0);
        end
        ready = 1'b1;
        step();
        chk("t2_idx2", idx, 2);
        chk("t2_data2", data, 30);
        step();
        chk("t2_data3", data, 40);
        chk("t2_last3", last, 1);
        step();
        chk("t2_busy_end", busy, 0);
        chk("t2_drop", dropped, 0);

        // periodic sampling, period 10
        counters = {8'd40, 8'd30, 8'd20, 8'd10};
        en = 1'b1;
        period = 8'd10;
        clr_cnt = 0;
        beat_cnt = 0;
        for (int k = 1; k <= 40; k++) begin
            step();
            chk("t3_clear_k", clear, (k % 10 == 0));
            if (clear) clr_cnt++;
            if (v) beat_cnt++;
        end
        chk("t3_clr_cnt", clr_cnt, 4);
        chk("t3_beats", beat_cnt, 12);
        chk("t3_drop", dropped, 0);
        en = 1'b0;
        for (int k = 0; k < 6; k++) step();
        chk("t3_idle", busy, 0);

        // drops during stalled SEND, saturation, clear with drop
        ready = 1'b0;
        en = 1'b1;
        period = 8'd3;
        for (int k = 1; k <= 60; k++) begin
            step();
            if (k == 3) chk("t4_snap", clear, 1);
            if (k == 5) chk("t4_drop5", dropped, 0);
            if (k == 6) chk("t4_drop6", dropped, 1);
            if (k == 9) chk("t4_drop9", dropped, 2);
        end
        chk("t4_sat", dropped, 15);
        step();
        step();
        chk("t4_sat_hold", dropped, 15);
        clear_drop = 1'b1;
        step();
        clear_drop = 1'b0;
        chk("t4_clr_tick", dropped, 1);
        en = 1'b0;
        ready = 1'b1;
        for (int k = 0; k < 4; k++) step();
        chk("t4_idle", busy, 0);
        clear_drop = 1'b1;
        step();
        clear_drop = 1'b0;
        chk("t4_clr", dropped, 0);

        // async reset mid-SEND
        trigger = 1'b1;
        step();
        trigger = 1'b0;
        step();
        step();
        step();
        chk("t5_idx2", idx, 2);
        #2;
        reset_n = 1'b0;
        #1;
        chk("t5_v_async", v, 0);
        chk("t5_busy_async", busy, 0);
        step();
        @(negedge clk);
        reset_n = 1'b1;
        beat_cnt = 0;
        for (int k = 0; k < 5; k++) begin
            step();
            if (v || busy) beat_cnt++;
        end
        chk("t5_no_resume", beat_cnt, 0);
        chk("t5_drop", dropped, 0);

        // trigger coincident with tick in IDLE
        en = 1'b1;
        period = 8'd5;
        for (int k = 0; k < 4; k++) step();
        chk("t6_idle", busy, 0);
        trigger = 1'b1;
        step();
        trigger = 1'b0;
        en = 1'b0;
        chk("t6_clear", clear, 1);
        beat_cnt = 0;
        clr_cnt = 0;
        for (int k = 0; k < 8; k++) begin
            step();
            if (v) beat_cnt++;
            if (clear) clr_cnt++;
        end
        chk("t6_beats", beat_cnt, 4);
        chk("t6_no_reclear", clr_cnt, 0);
        chk("t6_drop", dropped, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
